// File: rtl/bus_pkg.sv
// Shared bus constants: default widths and source indices in legacy select-line order.
package bus_pkg;

    localparam int unsigned WORD_DEF = 16;
    localparam int unsigned SRC_DEF  = 10;
    localparam int unsigned CNT_W    = 8;

    localparam int unsigned SRC_DIN = 0;
    localparam int unsigned SRC_G   = 1;
    localparam int unsigned SRC_R0  = 2;
    localparam int unsigned SRC_R1  = 3;
    localparam int unsigned SRC_R2  = 4;
    localparam int unsigned SRC_R3  = 5;
    localparam int unsigned SRC_R4  = 6;
    localparam int unsigned SRC_R5  = 7;
    localparam int unsigned SRC_R6  = 8;
    localparam int unsigned SRC_R7  = 9;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned SRC = 10,
    parameter int unsigned PW  = 4
) (
    input  logic [SRC-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [SRC-1:0] pick,
    output logic [PW-1:0]  idx
);

    localparam int unsigned PW1 = PW + 1;

    logic [PW:0]   pos;
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        sel   = '0;
        for (int unsigned k = 0; k < SRC; k++) begin
            pos = {1'b0, ptr} + PW1'(k);
            if (pos >= PW1'(SRC)) begin
                pos = pos - PW1'(SRC);
            end
            sel = PW'(pos);
            if (!found && req[sel]) begin
                found     = 1'b1;
                idx       = sel;
                pick[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered bus multiplexer with grant lock, conflict reporting and optional
// round-robin arbitration of simultaneous requests (enabled by BUS_ARB_EN).
module bus_arb_mux
    import bus_pkg::*;
#(
    parameter int unsigned WORD = WORD_DEF,
    parameter int unsigned SRC  = SRC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SRC-1:0]      req,
    input  logic                lock,
    input  logic [WORD*SRC-1:0] src_data,
    input  logic                err_clr,
    output logic [WORD-1:0]     bus,
    output logic [SRC-1:0]      grant,
    output logic                bus_vld,
    output logic                err,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int unsigned PW = (SRC > 1) ? $clog2(SRC) : 1;

    logic [WORD-1:0]  words [SRC];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [PW-1:0]    req_idx;
    logic [PW-1:0]    held_idx;
    logic [PW-1:0]    idx_nxt;
    logic [SRC-1:0]   grant_nxt;
    logic [WORD-1:0]  bus_nxt;
    logic             vld_nxt;
    logic             hold;
    logic             multi;
    logic             conflict;

    for (genvar i = 0; i < SRC; i++) begin : g_words
        assign words[i] = src_data[WORD*i +: WORD];
    end

    // Index encoders for the incoming one-hot request and the current grant.
    always_comb begin
        req_idx  = '0;
        held_idx = '0;
        for (int unsigned i = 0; i < SRC; i++) begin
            if (req[i]) begin
                req_idx = PW'(i);
            end
            if (grant[i]) begin
                held_idx = PW'(i);
            end
        end
    end

    assign hold  = lock && (|grant) && (|(req & grant));
    assign multi = |(req & (req - SRC'(1)));

`ifdef BUS_ARB_EN
    logic [SRC-1:0] rr_grant;
    logic [PW-1:0]  rr_idx;

    rr_pick #(
        .SRC (SRC),
        .PW  (PW)
    ) u_rr_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (rr_grant),
        .idx  (rr_idx)
    );
`endif

    // Selection: lock beats everything, then single request, then multi-request policy.
    always_comb begin
        grant_nxt = '0;
        idx_nxt   = '0;
        vld_nxt   = 1'b0;
        ptr_nxt   = ptr;
        conflict  = 1'b0;
        if (hold) begin
            grant_nxt = grant;
            idx_nxt   = held_idx;
            vld_nxt   = 1'b1;
        end else if (req == '0) begin
            vld_nxt = 1'b0;
        end else if (!multi) begin
            grant_nxt = req;
            idx_nxt   = req_idx;
            vld_nxt   = 1'b1;
            ptr_nxt   = (req_idx == PW'(SRC - 1)) ? '0 : req_idx + PW'(1);
        end else begin
`ifdef BUS_ARB_EN
            grant_nxt = rr_grant;
            idx_nxt   = rr_idx;
            vld_nxt   = 1'b1;
            ptr_nxt   = (rr_idx == PW'(SRC - 1)) ? '0 : rr_idx + PW'(1);
`else
            conflict  = 1'b1;
`endif
        end
        bus_nxt = vld_nxt ? words[idx_nxt] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus     <= '0;
            grant   <= '0;
            bus_vld <= 1'b0;
            ptr     <= '0;
        end else begin
            bus     <= bus_nxt;
            grant   <= grant_nxt;
            bus_vld <= vld_nxt;
            ptr     <= ptr_nxt;
        end
    end

    // Sticky flag and saturating counter; a same-cycle conflict wins over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            err     <= conflict;
            err_cnt <= conflict ? CNT_W'(1) : '0;
        end else if (conflict) begin
            err <= 1'b1;
            if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Registered, parametrised bus multiplexer for the datapath: it drives the shared CPU bus from one of `SRC` word-wide sources. Requests arrive from the control unit as a request vector with the same bit order as the legacy select lines (DIN, G, R0..R7 for `SRC=10`). It adds:

- a one-cycle registered output;
- round-robin arbitration of simultaneous requests;
- a grant lock for multi-cycle transfers;
- conflict error reporting.

It sits between the register file / G / DIN and the bus consumers (ALU A/G inputs, register load ports).

## Interface

- `WORD`, 16, bus and source width in bits
- `SRC`, 10, number of sources; source i occupies `src_data[WORD*i +: WORD]`

Clock and reset: one clock; reset is asynchronous and active-high.

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  SRC  request vector, bit i requests source i
- `lock`  in  1  hold current grant while its request stays high
- `src_data`  in  WORD*SRC  packed source words
- `err_clr`  in  1  clear `err` and `err_cnt`
- `bus`  out  WORD  registered bus value
- `grant`  out  SRC  registered one-hot grant (all-zero when idle)
- `bus_vld`  out  1  `bus` carries a granted source
- `err`  out  1  sticky conflict flag
- `err_cnt`  out  8  saturating conflict counter

## Operation

- **Reset:** `bus`=0, `grant`=0, `bus_vld`=0, `err`=0, `err_cnt`=0, round-robin pointer `ptr`=0.
- **Evaluation:** each rising edge samples `req`, `lock`, `src_data` and updates all outputs from those samples.
- **No request** (`req`=0): `bus`=0, `grant`=0, `bus_vld`=0. `ptr` is unchanged.
- **Single request** (one-hot): grant that source. `bus` = its word, `bus_vld`=1, `ptr` = index+1, wrapping `SRC`-1→0.
- **Lock:** if `lock`=1, `grant` is nonzero, and `req` of the granted source is still 1, the grant is held regardless of other requests. `bus` reloads that source's current word every cycle and `ptr` is unchanged. If the locked source drops its request, `lock` is ignored and normal selection applies in the same cycle.
- **Multiple requests:** behaviour depends on `BUS_ARB_EN` (see Configuration).
- **Error counter:** `err_cnt` saturates at 255.
- **`err_clr`:** zeroes `err` and `err_cnt`. If a conflict occurs in the same cycle, the result is `err`=1 and `err_cnt`=1.
- **Selection path:** pure index-based; no arithmetic on data. Unused high `src_data` bits do not exist because the width is exact.

## Timing

- **Latency:** 1 cycle from `req` to `bus`/`grant`/`bus_vld`. There is no combinational path from inputs to outputs.
- **Throughput:** a new selection every cycle.
- **Reset mid-transfer:** outputs clear immediately (asynchronously), lock state is lost, and `ptr` returns to 0.
- **Release:** a lock release takes effect on the same edge that samples `lock`=0.

## Configuration

`BUS_ARB_EN` controls how multiple simultaneous requests are handled.

- **Defined:** round-robin arbitration. Grant the first requesting index ≥ `ptr`, searching upward and wrapping; then `ptr` = granted index+1. `err` and `err_cnt` stay 0.
- **Undefined (legacy-compatible):** `bus`=0, `grant`=0, `bus_vld`=0, `err` set, `err_cnt` increments, `ptr` unchanged. Lock still applies, because a held grant is not a conflict.

## Structure

- **Shared package `bus_pkg`:** `WORD_DEF`=16, `SRC_DEF`=10, and source index constants `SRC_DIN`=0, `SRC_G`=1, `SRC_R0`=2 … `SRC_R7`=9.
- **Sub-module `rr_pick`:** combinational; inputs `req` and `ptr`, outputs one-hot pick and its index. It is instantiated only under `BUS_ARB_EN`.
- **Top level:** lock/conflict logic, output registers, error counter.

## Test plan

- Reset asserted mid-lock with `bus`=16'hBEEF: all outputs go 0 immediately; after release with `req`=10'b00_0000_0001 and DIN=16'h1234, `bus`=16'h1234 and `grant`=10'b1 one edge later.
- `req` one-hot on R7 (bit 9), R7 word 16'hA5A5: one cycle later `bus`=16'hA5A5, `bus_vld`=1. Then `req`=0: `bus`=0, `bus_vld`=0.
- With `BUS_ARB_EN`, hold `req`=10'b00_0000_0110: grants alternate G, R0, G, R0. From `ptr`=9 with `req` bits 9 and 1 set, bit 9 is granted, then bit 1 (wrap).
- Lock on R2 (bit 4) while R5 also requests; change R2's word 16'h0001→16'h0002: `bus` follows R2 for 3 cycles. R2 drops its request: R5 is granted next edge.
- Without `BUS_ARB_EN`, `req`=10'b00_0000_0011 for 300 cycles: `bus`=0, `err`=1, `err_cnt`=255. Pulse `err_clr` during a conflict: `err_cnt`=1.
- Without `BUS_ARB_EN`, `SRC`=4, `WORD`=8, parameter sweep: each one-hot request returns its source byte, and 2-hot requests flag `err`.
